ps2_device_tx: RTL and testbench

Synthesizable PS/2 device-side transmitter; it plays the keyboard end of the PS2C/PS2D link. It accepts bytes (scan codes) over a valid/ready handshake and emits standard 11-bit device-to-host frames, generating the PS/2 clock itself with open-collector style drive. Instantiated next to the alarm_clock top on Basys2 as a loopback keyboard model, and reusable as a bench stimulus source for the PS/2 receiver path.

---
 rtl/ps2_device_tx_pkg.sv | 34 +++
 rtl/ps2_device_tx_sync.sv | 25 ++
 rtl/ps2_device_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_device_tx_pkg.sv
// Shared types and constants for the PS/2 device-side transmitter.
// Holds the FSM state type, frame geometry, default timing and the frame builder.
package ps2_device_tx_pkg;

    // Transmitter states, in the order a normal frame visits them
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_SETUP,
        ST_CLK_LOW,
        ST_CLK_HIGH,
        ST_DONE,
        ST_ABORT
    } state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    // Defaults for a 50 MHz MCLK
    localparam int DEF_HALF_BIT  = 2000;
    localparam int DEF_IDLE_HOLD = 2500;
    localparam int DEF_GUARD     = 4;

    // Odd parity: the parity bit makes the count of ones over data+parity odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame image as shifted out LSB first: start bit sits in bit 0
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_device_tx_sync.sv
// Two-flop synchronizer for one raw PS/2 line; flops reset to 1 (released bus).
// Ports: clk_i, rst_i (async, active high), d_i raw level, q_o synchronized level.
module ps2_device_tx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = {sync_q[0], d_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side (keyboard end) transmitter: takes bytes over valid/ready and
// sends 11-bit device-to-host frames, generating PS2C itself via open-collector enables.
// Ports: MCLK, reset (async high); tx_data/tx_valid/tx_ready byte handshake;
//        ps2c_in/ps2d_in raw line levels; ps2c_oe/ps2d_oe pull-low enables;
//        busy, tx_done (frame sent pulse), tx_abort (host inhibit pulse).
module ps2_device_tx
    import ps2_device_tx_pkg::*;
#(
    parameter int HALF_BIT  = DEF_HALF_BIT,
    parameter int IDLE_HOLD = DEF_IDLE_HOLD,
    parameter int GUARD     = DEF_GUARD
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    // One counter serves both the bus-idle hold and the per-phase timing,
    // since those never run at the same time.
    localparam int MAX_CNT = (IDLE_HOLD > HALF_BIT) ? IDLE_HOLD : HALF_BIT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_END = CW'(IDLE_HOLD - 1);
    localparam logic [CW-1:0] LOW_END  = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] HIGH_END = CW'(HALF_BIT / 2 - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_LEN - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;

    logic c_sync;
    logic d_sync;
    logic inhibit;

    ps2_device_tx_sync u_sync_c (
        .clk_i (MCLK),
        .rst_i (reset),
        .d_i   (ps2c_in),
        .q_o   (c_sync)
    );

    ps2_device_tx_sync u_sync_d (
        .clk_i (MCLK),
        .rst_i (reset),
        .d_i   (ps2d_in),
        .q_o   (d_sync)
    );

    // PS2C was just released at the start of SETUP/CLK_HIGH; wait out the
    // synchronizer latency before reading a low PS2C as the host inhibiting.
    assign inhibit = (cnt_q >= GUARD_C) && !c_sync;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = build_frame(tx_data);
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_BUS;
                end
            end

            ST_WAIT_BUS: begin
                // Any low sample restarts the idle window; no abort here
                if (c_sync && d_sync) begin
                    if (cnt_q == HOLD_END) begin
                        cnt_d   = '0;
                        state_d = ST_SETUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            ST_SETUP: begin
                if (inhibit) begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end else if (cnt_q == HIGH_END) begin
                    cnt_d   = '0;
                    state_d = ST_CLK_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CLK_LOW: begin
                if (cnt_q == LOW_END) begin
                    cnt_d   = '0;
                    state_d = ST_CLK_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CLK_HIGH: begin
                if (inhibit) begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end else if (cnt_q == HIGH_END) begin
                    cnt_d     = '0;
                    shift_d   = {1'b1, shift_q[FRAME_LEN-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end

            ST_ABORT: begin
                // The byte is dropped; the client decides whether to resend
                shift_d   = '0;
                bit_cnt_d = '0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Line enables decode straight from the state register so an async
    // reset releases the bus in the same cycle.
    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b1;
        ps2c_oe  = 1'b0;
        ps2d_oe  = 1'b0;
        tx_done  = 1'b0;
        tx_abort = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_SETUP: begin
                ps2d_oe = ~shift_q[0];
            end
            ST_CLK_LOW: begin
                ps2c_oe = 1'b1;
                ps2d_oe = ~shift_q[0];
            end
            ST_CLK_HIGH: begin
                ps2d_oe = ~shift_q[0];
            end
            ST_DONE: begin
                tx_done = 1'b1;
            end
            ST_ABORT: begin
                tx_abort = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx with a pulled-up bus and a host model.
// Frames are decoded by a falling-edge receiver and compared to a byte-level model.
module tb_ps2_device_tx;

    localparam int HB    = 16;
    localparam int IH    = 20;
    localparam int GD    = 4;
    localparam int BIT_P = 2 * HB;
    localparam int START_OFF = IH + HB / 2;
    localparam int DONE_LAT  = 11 * BIT_P - HB / 2;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_abort;

    logic host_c_low = 1'b0;
    logic host_d_low = 1'b0;
    logic ps2c_line;
    logic ps2d_line;

    // Open-collector bus with pull-ups: any driver pulling low wins
    assign ps2c_line = ~(ps2c_oe | host_c_low);
    assign ps2d_line = ~(ps2d_oe | host_d_low);

    ps2_device_tx #(
        .HALF_BIT  (HB),
        .IDLE_HOLD (IH),
        .GUARD     (GD)
    ) dut (
        .MCLK     (MCLK),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ps2c_in  (ps2c_line),
        .ps2d_in  (ps2d_line),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_abort (tx_abort)
    );

    always #5 MCLK = ~MCLK;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int accept_cnt = 0;
    int c_rise_cnt = 0;
    int viol = 0;
    int last_done_cyc = 0;
    int last_c_rise_cyc = 0;
    logic prev_c_oe = 1'b0;

    int acc_cyc = 0;
    int base_rise = 0;
    int base_done = 0;
    int base_abort = 0;

    bit rx_bits[$];

    always @(posedge MCLK) cyc <= cyc + 1;

    always @(negedge MCLK) begin
        prev_c_oe <= ps2c_oe;
        if (ps2c_oe && !prev_c_oe) begin
            c_rise_cnt      <= c_rise_cnt + 1;
            last_c_rise_cyc <= cyc;
        end
        if (tx_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (tx_abort) abort_cnt <= abort_cnt + 1;
        if (tx_valid && tx_ready && !reset) accept_cnt <= accept_cnt + 1;
        if (!busy && (ps2c_oe || ps2d_oe)) viol <= viol + 1;
        if (tx_ready == busy) viol <= viol + 1;
    end

    // Host receiver: samples PS2D on every PS2C falling edge
    always @(negedge ps2c_line) rx_bits.push_back(ps2d_line);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;
    } vec_t;

    vec_t tbl[5];

    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            tick(1);
            n++;
        end
        if (!tx_ready) timeout_fail(name);
    endtask

    task automatic wait_rise(input int target, input string name);
        int n = 0;
        while (c_rise_cnt < target && n < 2000) begin
            tick(1);
            n++;
        end
        if (c_rise_cnt < target) timeout_fail(name);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            tick(1);
            n++;
        end
        if (done_cnt < target) timeout_fail(name);
    endtask

    // Expected frame from the protocol rules: start 0, data LSB first,
    // parity making the one-count of data+parity odd, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    function automatic int frame_ok(input logic [10:0] f);
        int ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        return (f[0] == 1'b0 && f[10] == 1'b1 && ones % 2 == 1) ? 1 : 0;
    endfunction

    function automatic logic [10:0] pack_bits(input int start);
        logic [10:0] f = '0;
        for (int i = 0; i < 11; i++) begin
            if (start + i < rx_bits.size()) f[i] = rx_bits[start + i];
        end
        return f;
    endfunction

    task automatic accept(input logic [7:0] d, input string name);
        wait_ready(name);
        rx_bits.delete();
        base_rise  = c_rise_cnt;
        base_done  = done_cnt;
        base_abort = abort_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        acc_cyc  = cyc;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk({name, " ready drop"}, int'(tx_ready), 0);
    endtask

    task automatic collect(input logic [7:0] d, input int ref_cyc, input int tol,
                           input string name, output logic [10:0] got);
        int first;
        wait_rise(base_rise + 1, {name, " first clk"});
        first = last_c_rise_cyc;
        chk_range({name, " start"}, first - ref_cyc, START_OFF, START_OFF + tol);
        wait_done(base_done + 1, {name, " done"});
        chk({name, " done latency"}, last_done_cyc - first, DONE_LAT);
        tick(2);
        chk({name, " done pulses"}, done_cnt - base_done, 1);
        chk({name, " aborts"}, abort_cnt - base_abort, 0);
        chk({name, " clk edges"}, c_rise_cnt - base_rise, 11);
        chk({name, " rx bits"}, rx_bits.size(), 11);
        got = pack_bits(0);
        chk({name, " frame"}, int'(got), int'(model_frame(d)));
        chk({name, " decoded"}, int'(got[8:1]), int'(d));
        chk({name, " parity ok"}, frame_ok(got), 1);
    endtask

    initial begin
        logic [10:0] got;
        logic [7:0]  rb;
        int a0;
        int r1;
        int first_done;
        int n;
        int rel;

        tbl[0] = '{8'h1C, 11'b100_0011_1000};
        tbl[1] = '{8'hF0, 11'b111_1110_0000};
        tbl[2] = '{8'h00, 11'b110_0000_0000};
        tbl[3] = '{8'hFF, 11'b111_1111_1110};
        tbl[4] = '{8'h01, 11'b100_0000_0010};

        tick(3);
        chk("rst ready", int'(tx_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst oe", int'({ps2c_oe, ps2d_oe}), 0);
        chk("rst pulses", int'({tx_done, tx_abort}), 0);
        reset = 1'b0;
        tick(30);

        for (int i = 0; i < 5; i++) begin
            accept(tbl[i].data, $sformatf("tbl%0d", i));
            collect(tbl[i].data, acc_cyc, 0, $sformatf("tbl%0d", i), got);
            chk($sformatf("tbl%0d bits", i), int'(got), int'(tbl[i].bits));
        end

        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            accept(rb, $sformatf("rnd%0d", i));
            collect(rb, acc_cyc, 0, $sformatf("rnd%0d", i), got);
        end

        // Back-to-back with tx_valid held across the first frame
        wait_ready("bb");
        rx_bits.delete();
        base_rise = c_rise_cnt;
        base_done = done_cnt;
        a0 = accept_cnt;
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick(1);
        tx_data = 8'h1C;
        wait_done(base_done + 1, "bb first done");
        first_done = last_done_cyc;
        n = 0;
        while (!tx_ready && n < 100) begin
            tick(1);
            n++;
        end
        chk("bb ready back", int'(tx_ready), 1);
        chk("bb accepts while busy", accept_cnt - a0, 1);
        r1 = c_rise_cnt;
        tick(1);
        tx_valid = 1'b0;
        chk("bb ready drop", int'(tx_ready), 0);
        wait_rise(r1 + 1, "bb second clk");
        chk_range("bb idle gap", last_c_rise_cyc - first_done, IH, 1000);
        wait_done(base_done + 2, "bb second done");
        tick(2);
        chk("bb accepts", accept_cnt - a0, 2);
        chk("bb rx bits", rx_bits.size(), 22);
        chk("bb frame1", int'(pack_bits(0)), int'(model_frame(8'hF0)));
        chk("bb frame2", int'(pack_bits(11)), int'(model_frame(8'h1C)));
        chk("bb parity", frame_ok(pack_bits(0)) + frame_ok(pack_bits(11)), 2);

        // Host inhibit during bit 4's clock-high phase
        accept(8'h3C, "inh");
        wait_rise(base_rise + 5, "inh bit4");
        n = 0;
        while (ps2c_oe && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        host_c_low = 1'b1;
        tick(50);
        chk("inh released mid", int'({ps2c_oe, ps2d_oe}), 0);
        chk("inh busy mid", int'(busy), 0);
        tick(50);
        host_c_low = 1'b0;
        tick(60);
        chk("inh abort pulses", abort_cnt - base_abort, 1);
        chk("inh no done", done_cnt - base_done, 0);
        chk("inh clk edges", c_rise_cnt - base_rise, 5);
        chk("inh oe", int'({ps2c_oe, ps2d_oe}), 0);
        chk("inh ready", int'(tx_ready), 1);

        // Host holds PS2D low before the send
        host_d_low = 1'b1;
        tick(3);
        accept(8'h5A, "hold");
        tick(200);
        chk("hold busy", int'(busy), 1);
        chk("hold no clk", c_rise_cnt - base_rise, 0);
        chk("hold no abort", abort_cnt - base_abort, 0);
        host_d_low = 1'b0;
        rel = cyc;
        collect(8'h5A, rel, 3, "hold", got);

        // Reset during bit 6's clock-low phase
        accept(8'h00, "rst");
        wait_rise(base_rise + 7, "rst bit6");
        tick(2);
        chk("rst pre clk", int'(ps2c_oe), 1);
        chk("rst pre data", int'(ps2d_oe), 1);
        reset = 1'b1;
        #1;
        chk("rst async release", int'({ps2c_oe, ps2d_oe}), 0);
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst ready after", int'(tx_ready), 1);
        chk("rst busy after", int'(busy), 0);
        chk("rst no pulses", (done_cnt - base_done) + (abort_cnt - base_abort), 0);
        tick(5);
        accept(8'hA5, "post");
        collect(8'hA5, acc_cyc, 0, "post", got);

        chk("line invariants", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
